// File: rtl/sha2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sha2_pkg                                                                   |
// | Shared SHA-2 constants, schedule state encoding and sigma0/sigma1 helpers.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package sha2_pkg;

    localparam int unsigned W32_WORD   = 32;
    localparam int unsigned W32_ROUNDS = 64;
    localparam int unsigned W64_WORD   = 64;
    localparam int unsigned W64_ROUNDS = 80;
    localparam int unsigned WIN_DEPTH  = 16;
    localparam int unsigned IDX_W      = 7;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_GEN  = 1'b1
    } state_e;

    localparam int unsigned S0_ROT_A_32 = 7;
    localparam int unsigned S0_ROT_B_32 = 18;
    localparam int unsigned S0_SHR_32   = 3;
    localparam int unsigned S1_ROT_A_32 = 17;
    localparam int unsigned S1_ROT_B_32 = 19;
    localparam int unsigned S1_SHR_32   = 10;

    localparam int unsigned S0_ROT_A_64 = 1;
    localparam int unsigned S0_ROT_B_64 = 8;
    localparam int unsigned S0_SHR_64   = 7;
    localparam int unsigned S1_ROT_A_64 = 19;
    localparam int unsigned S1_ROT_B_64 = 61;
    localparam int unsigned S1_SHR_64   = 6;

    function automatic bit cfg_legal(input int unsigned word_w, input int unsigned rounds);
        return ((word_w == W32_WORD) && (rounds == W32_ROUNDS)) ||
               ((word_w == W64_WORD) && (rounds == W64_ROUNDS));
    endfunction

    function automatic logic [31:0] rotr_w32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr_w64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [31:0] sigma0_w32(input logic [31:0] x);
        return rotr_w32(x, S0_ROT_A_32) ^ rotr_w32(x, S0_ROT_B_32) ^ (x >> S0_SHR_32);
    endfunction

    function automatic logic [31:0] sigma1_w32(input logic [31:0] x);
        return rotr_w32(x, S1_ROT_A_32) ^ rotr_w32(x, S1_ROT_B_32) ^ (x >> S1_SHR_32);
    endfunction

    function automatic logic [63:0] sigma0_w64(input logic [63:0] x);
        return rotr_w64(x, S0_ROT_A_64) ^ rotr_w64(x, S0_ROT_B_64) ^ (x >> S0_SHR_64);
    endfunction

    function automatic logic [63:0] sigma1_w64(input logic [63:0] x);
        return rotr_w64(x, S1_ROT_A_64) ^ rotr_w64(x, S1_ROT_B_64) ^ (x >> S1_SHR_64);
    endfunction

endpackage
`default_nettype wire

// File: rtl/msg_schedule_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | msg_schedule_if                                                            |
// | Message-word input and schedule-word output handshakes of msg_schedule.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface msg_schedule_if #(
    parameter int unsigned WORD_W = 32
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [WORD_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [WORD_W-1:0] out_data_o;
    logic [6:0]        out_idx_o;
    logic              out_last_o;

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o
    );

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o
    );
endinterface
`default_nettype wire

// File: rtl/msg_sigma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | msg_sigma                                                                  |
// | Combinational SHA-2 small sigma0/sigma1 for 32- or 64-bit words.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module msg_sigma
    import sha2_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic [WORD_W-1:0] x0_i,
    input  logic [WORD_W-1:0] x1_i,
    output logic [WORD_W-1:0] s0_o,
    output logic [WORD_W-1:0] s1_o
);

    if (WORD_W == W64_WORD) begin : g_w64
        assign s0_o = sigma0_w64(x0_i);
        assign s1_o = sigma1_w64(x1_i);
    end else begin : g_w32
        assign s0_o = sigma0_w32(x0_i);
        assign s1_o = sigma1_w32(x1_i);
    end

endmodule
`default_nettype wire

// File: rtl/msg_schedule.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | msg_schedule                                                               |
// | SHA-2 message-schedule generator: 16 loaded words, then W16..W(ROUNDS-1).  |
// | Option: MSG_SCHEDULE_PRESUM_EN registers W(t-16)+s0(W(t-15))+W(t-7).       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module msg_schedule
    import sha2_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ROUNDS = 64
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    msg_schedule_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] LOAD_LAST_IDX = IDX_W'(WIN_DEPTH - 1);

    if (!cfg_legal(WORD_W, ROUNDS)) begin : g_bad_cfg
        $error("msg_schedule: WORD_W/ROUNDS must be 32/64 or 64/80");
    end

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  t_q, t_d;
    logic [WORD_W-1:0] win_q [WIN_DEPTH];
    logic [WORD_W-1:0] win_d [WIN_DEPTH];
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;

    logic              advance, accept, produce;
    logic [WORD_W-1:0] sig0, sig1, gen_word, new_word;

    assign advance  = !out_valid_q || bus.out_ready_i;
    assign accept   = (state_q == ST_LOAD) && advance && bus.in_valid_i;
    assign produce  = accept || ((state_q == ST_GEN) && advance);
    assign new_word = (state_q == ST_LOAD) ? bus.in_data_i : gen_word;

`ifdef MSG_SCHEDULE_PRESUM_EN
    logic [WORD_W-1:0] presum_q, presum_d;

    // Taps are one slot higher than for Wt: the window shifts on the same edge.
    msg_sigma #(.WORD_W(WORD_W)) u_sigma (
        .x0_i (win_q[2]),
        .x1_i (win_q[14]),
        .s0_o (sig0),
        .s1_o (sig1)
    );

    assign gen_word = sig1 + presum_q;

    always_comb begin
        presum_d = presum_q;
        if (flush_i) begin
            presum_d = '0;
        end else if (produce) begin
            presum_d = win_q[1] + sig0 + win_q[10];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presum_q <= '0;
        end else begin
            presum_q <= presum_d;
        end
    end
`else
    msg_sigma #(.WORD_W(WORD_W)) u_sigma (
        .x0_i (win_q[1]),
        .x1_i (win_q[14]),
        .s0_o (sig0),
        .s1_o (sig1)
    );

    assign gen_word = sig1 + win_q[9] + sig0 + win_q[0];
`endif

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        win_d       = win_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;

        if (advance) begin
            out_valid_d = produce;
            out_last_d  = produce && (t_q == LAST_IDX);
        end

        if (produce) begin
            out_data_d = new_word;
            out_idx_d  = t_q;
            for (int i = 0; i < WIN_DEPTH - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[WIN_DEPTH-1] = new_word;
            if (t_q == LAST_IDX) begin
                t_d     = '0;
                state_d = ST_LOAD;
            end else begin
                t_d = t_q + 1'b1;
                if (t_q == LOAD_LAST_IDX) begin
                    state_d = ST_GEN;
                end
            end
        end

        // Abort wins over any concurrent load or generate.
        if (flush_i) begin
            state_d     = ST_LOAD;
            t_d         = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            for (int i = 0; i < WIN_DEPTH; i++) begin
                win_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_LOAD;
            t_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < WIN_DEPTH; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            win_q       <= win_d;
        end
    end

    assign bus.in_ready_o  = (state_q == ST_LOAD) && advance;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_idx_o   = out_idx_q;
    assign bus.out_last_o  = out_last_q;

endmodule
`default_nettype wire
